// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage RV32 core: load-use bubbles, redirect flushes, dmem wait freeze.
// Optional HAZARD_PERF_EN adds saturating stall/flush/load-use counters (and the CNT_W parameter).
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  input  logic       ex_regwrite_i,
  input  logic       ex_redirect_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  output logic       pc_stall_o,
  output logic       if_id_stall_o,
  output logic       if_id_flush_o,
  output logic       id_ex_stall_o,
  output logic       id_ex_flush_o,
  output logic       ex_mem_stall_o,
  output logic       mem_wb_flush_o,
  output logic [1:0] state_o,
  output logic       err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] lu_cnt_o
`endif
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
  localparam logic [WC_W-1:0] WC_ZERO = WC_W'(0);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]      state_r, state_nx_s;
  logic [WC_W-1:0] wait_cnt_r, wait_cnt_nx_s;
  logic            err_r, err_nx_s;
  logic            load_use_s, freeze_s, run_rules_s;
  logic            redirect_act_s, lu_act_s;

  assign load_use_s = ex_memread_i & ex_regwrite_i & (ex_rd_i != 5'd0) &
                      ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));

  // Next-state logic; run_rules_s marks cycles where redirect/load-use may act.
  always_comb begin
    state_nx_s    = state_r;
    wait_cnt_nx_s = wait_cnt_r;
    err_nx_s      = err_r;
    freeze_s      = 1'b0;
    run_rules_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (dmem_req_i & ~dmem_ack_i) begin
          freeze_s      = 1'b1;
          state_nx_s    = ST_WAIT;
          wait_cnt_nx_s = WC_ONE;
        end else begin
          run_rules_s   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_ack_i) begin
          run_rules_s   = 1'b1;
          state_nx_s    = ST_RUN;
          wait_cnt_nx_s = WC_ZERO;
        end else if (wait_cnt_r == WC_MAX) begin
          freeze_s      = 1'b1;
          state_nx_s    = ST_ERR;
          err_nx_s      = 1'b1;
        end else begin
          freeze_s      = 1'b1;
          wait_cnt_nx_s = wait_cnt_r + WC_ONE;
        end
      end
      ST_ERR: begin
        freeze_s = 1'b1;
      end
      default: begin
        // Corrupted state encoding is treated as a fatal fault.
        freeze_s   = 1'b1;
        state_nx_s = ST_ERR;
        err_nx_s   = 1'b1;
      end
    endcase
  end

  assign redirect_act_s = run_rules_s & ex_redirect_i;
  assign lu_act_s       = run_rules_s & ~ex_redirect_i & load_use_s;

  // Outputs are gated by reset so they drop the instant reset_i falls.
  assign pc_stall_o     = reset_i & (freeze_s | lu_act_s);
  assign if_id_stall_o  = reset_i & (freeze_s | lu_act_s);
  assign if_id_flush_o  = reset_i & redirect_act_s;
  assign id_ex_stall_o  = reset_i & freeze_s;
  assign id_ex_flush_o  = reset_i & (redirect_act_s | lu_act_s);
  assign ex_mem_stall_o = reset_i & freeze_s;
  assign mem_wb_flush_o = reset_i & freeze_s;
  assign state_o        = reset_i ? state_r : ST_RUN;
  assign err_o          = reset_i & err_r;

  // FSM, wait counter and sticky error.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= WC_ZERO;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      wait_cnt_r <= wait_cnt_nx_s;
      err_r      <= err_nx_s;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r, lu_cnt_r;
  logic             cnt_en_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  assign cnt_en_s = (state_r != ST_ERR);

  // Saturating performance counters, frozen while in ERR.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      lu_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= sat_inc(stall_cnt_r, cnt_en_s & pc_stall_o);
      flush_cnt_r <= sat_inc(flush_cnt_r, cnt_en_s & if_id_flush_o);
      lu_cnt_r    <= sat_inc(lu_cnt_r, cnt_en_s & lu_act_s);
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
  assign lu_cnt_o    = lu_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (MEM_TIMEOUT=4): directed steps then random traffic against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread, ex_regwrite, ex_redirect, dmem_req, dmem_ack;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
  logic [1:0] state;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: is a miss outstanding, how many frozen cycles it has used, has it timed out.
  bit m_in_reset;
  bit m_miss;
  int m_elapsed;
  bit m_dead;

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(id_uses_rs2),
    .ex_rd_i(ex_rd), .ex_memread_i(ex_memread), .ex_regwrite_i(ex_regwrite),
    .ex_redirect_i(ex_redirect), .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush), .ex_mem_stall_o(ex_mem_stall),
    .mem_wb_flush_o(mem_wb_flush), .state_o(state), .err_o(err)
  );

  always #5 clk = ~clk;

  // Expected {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, state[1:0], err}.
  function automatic logic [9:0] expect_out();
    logic       lu;
    logic [6:0] ctl;
    logic [1:0] st;
    lu = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
         ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    if (m_in_reset) return 10'd0;
    if (m_dead) return {7'b1101011, 2'd2, 1'b1};
    st = m_miss ? 2'd1 : 2'd0;
    if ((m_miss && !dmem_ack) || (!m_miss && dmem_req && !dmem_ack)) ctl = 7'b1101011;
    else if (ex_redirect) ctl = 7'b0010100;
    else if (lu) ctl = 7'b1100100;
    else ctl = 7'b0000000;
    return {ctl, st, 1'b0};
  endfunction

  task automatic model_clock();
    if (m_in_reset || m_dead) begin
      // nothing changes
    end else if (m_miss) begin
      if (dmem_ack) m_miss = 1'b0;
      else begin
        m_elapsed++;
        if (m_elapsed > TMO) begin m_dead = 1'b1; m_miss = 1'b0; end
      end
    end else if (dmem_req && !dmem_ack) begin
      m_miss = 1'b1;
      m_elapsed = 1;
    end
  endtask

  task automatic model_reset();
    m_miss = 1'b0; m_elapsed = 0; m_dead = 1'b0;
  endtask

  task automatic chk(input string tag);
    logic [9:0] obs, exp;
    exp = expect_out();
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, state, err};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic rdr, input logic req, input logic ack);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_rd = rd;
    ex_memread = mr; ex_regwrite = rw; ex_redirect = rdr; dmem_req = req; dmem_ack = ack;
  endtask

  // One cycle: inputs set at the falling edge, outputs checked 1ns later, model advanced at the rising edge.
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic rw, input logic rdr,
                      input logic req, input logic ack);
    drive(rs1, rs2, u2, rd, mr, rw, rdr, req, ack);
    #1;
    chk(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the low clock phase, with hazard-provoking inputs held.
  task automatic async_reset(input string tag);
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    reset_i = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    #1;
    chk(tag);
    @(posedge clk);
    #1;
    chk({tag, "_hold"});
    @(negedge clk);
    reset_i = 1'b1;
    m_in_reset = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    chk("reset_outputs");
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    m_in_reset = 1'b0;

    // Load-use detection and its qualifiers
    step("lu_rs1",        5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_after",      5'd1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rd0",        5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2_unused", 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2_used",   5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_no_regwr",   5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("redir_over_lu", 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Three-cycle miss, then a same-cycle ack
    step("miss_req",   5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("miss_w1",    5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("miss_w2",    5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("miss_ack",   5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step("miss_done",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hit_same",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Ack on the last allowed wait cycle still succeeds
    for (int i = 0; i < TMO; i++) step("late_wait", 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("late_ack",   5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step("late_after", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout into ERR, which ignores a later ack
    for (int i = 0; i < TMO + 1; i++) step("tmo_wait", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("err_hold",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("err_hold2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset("rst_in_err");
    step("post_err_rst", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while in MEM_WAIT; req drop without ack still counts toward timeout
    step("w_req",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("w_drop", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset("rst_in_wait");
    step("post_wait_rst", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rand_rst");
      else step("rand",
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
